sd_sector_packer: RTL and testbench
===================================

// Module: sd_sector_packer
// PURPOSE
//  Byte-stream to sector packer sitting directly upstream of the SD single-block writer.
//  Collects an incoming byte stream into two ping-pong 512-byte banks.
//  Starts one single-block write per full bank at a consecutive sector address.
//  Serves the bank's bytes to the writer one per byte acknowledge.
// PARAMETERS
//  BASE_SECTOR  32'd0  sector address of the first block written
//  MAX_SECTORS  32'd0  total sectors to write before halting; 0 = unlimited
// PORTS
//  clk          in   1   system clock, single domain
//  rstn         in   1   asynchronous active-low reset
//  in_en        in   1   byte strobe from data source
//  in_byte      in   8   source byte
//  in_ready     out  1   1 = a free bank slot exists; in_en is accepted only when 1
//  wr_busy      in   1   writer busy (card not idle / not initialised)
//  wr_start     out  1   one-cycle pulse: start single-block write
//  wr_sector    out  32  sector address for the write, stable from wr_start until wr_done
//  wr_byte      out  8   current byte presented to the writer
//  wr_byte_ack  in   1   writer consumed wr_byte; advance to next
//  wr_done      in   1   writer block-finish pulse
//  sectors_done out  32  count of completed sector writes
//  overflow     out  1   sticky: in_en seen while in_ready=0
//  halted       out  1   MAX_SECTORS reached
// BEHAVIOUR
//  Reset values: in_ready=1, wr_start=0, wr_sector=BASE_SECTOR, wr_byte=0, sectors_done=0, overflow=0, halted=0.
//  Reset values (internal): fill/drain bank=0, pointers=0, full_cnt=0, FSM=IDLE. Reset mid-write aborts all; buffered data is discarded.
//  Fill side: on in_en & in_ready, write in_byte to bank[fill_bank][fill_ptr], fill_ptr++ (9-bit).
//  Fill side: when fill_ptr wraps 511->0, mark bank full (full_cnt++) and toggle fill_bank.
//  in_ready = (full_cnt<2) & ~halted. in_en while ~in_ready: byte dropped, overflow<=1 until reset.
//  Drain FSM: IDLE -> START -> XFER -> WAIT_DONE -> IDLE.
//   IDLE:      if full_cnt>0 & ~wr_busy & ~halted -> START.
//   START:     wr_start=1 for exactly one cycle; wr_byte=byte 0 of drain bank; rd_ptr=0 -> XFER.
//   XFER:      on wr_byte_ack, rd_ptr++ and wr_byte updates to the next byte by the following cycle.
//   XFER:      ack on rd_ptr=511 -> WAIT_DONE. Acks beyond 512 are ignored.
//   WAIT_DONE: on wr_done, release bank (full_cnt--), toggle drain_bank, wr_sector++ (32-bit wrap).
//   WAIT_DONE: sectors_done++ on wr_done; if MAX_SECTORS!=0 & sectors_done+1==MAX_SECTORS then halted<=1. -> IDLE.
//  Simultaneous bank-full and bank-release in one cycle: full_cnt unchanged, both bank toggles apply.
//  wr_done outside WAIT_DONE is ignored. wr_byte_ack outside XFER is ignored.
//  Bank memory: 2x512x8 synchronous RAM, one write port (fill), one read port (drain).
//  Latency: a filled bank issues wr_start 2 cycles after its last byte, given IDLE and ~wr_busy.
// CONFIGURATION
//  SECTOR_PACKER_FLUSH_EN defined: adds input port flush (1 bit).
//   A flush pulse with fill_ptr!=0 pads the rest of the current bank with 8'h00.
//   Padding writes one byte per cycle, with in_ready=0 during padding, then marks the bank full.
//   A flush pulse with fill_ptr==0 is a no-op.
//  SECTOR_PACKER_FLUSH_EN undefined: no flush port; a partial bank is held until completed.
// TESTING
//  Push 512 bytes 0..255,0..255 with wr_busy=0 -> single wr_start, wr_sector=BASE_SECTOR.
//   Acked bytes must match in order; on wr_done, sectors_done=1 and wr_sector=BASE_SECTOR+1.
//  Push 1536 bytes with writer stalled (no acks) -> in_ready=0 after byte 1024.
//   Extra in_en sets overflow=1; bytes 1024+ are dropped.
//  MAX_SECTORS=2, push 2048 bytes -> exactly 2 wr_start, halted=1 after second wr_done, in_ready=0.
//  Last fill byte lands in the same cycle as wr_done of the other bank -> full_cnt stays 1, no data loss.
//  Assert rstn low during XFER at rd_ptr=100 -> all outputs at reset values; next sector restarts at BASE_SECTOR.
//  FLUSH_EN: push 3 bytes AA,BB,CC then flush -> sector written as AA BB CC followed by 509 x 00.

Source files
------------

// File: rtl/sd_sector_packer.sv
// sd_sector_packer: packs a byte stream into ping-pong 512-byte banks and feeds one SD single-block write per bank.
// Define SECTOR_PACKER_FLUSH_EN to add a flush input that zero-pads a partial bank.
module sd_sector_packer #(
  parameter logic [31:0] BASE_SECTOR = 32'd0,
  parameter logic [31:0] MAX_SECTORS = 32'd0
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        in_en,
  input  logic [7:0]  in_byte,
  output logic        in_ready,
  input  logic        wr_busy,
  output logic        wr_start,
  output logic [31:0] wr_sector,
  output logic [7:0]  wr_byte,
  input  logic        wr_byte_ack,
  input  logic        wr_done,
  output logic [31:0] sectors_done,
  output logic        overflow,
`ifdef SECTOR_PACKER_FLUSH_EN
  input  logic        flush,
`endif
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, START, XFER, WAIT_DONE} state_t;
  state_t state;
  logic [7:0] mem [0:1023];
  logic fill_bank, drain_bank, pad, fill_we, bank_full, bank_rel;
  logic [8:0] fill_ptr, rd_ptr;
  logic [1:0] full_cnt;
  logic [7:0] fill_data;
  assign in_ready = (full_cnt < 2'd2) & ~halted & ~pad;
  assign fill_we = (in_en & in_ready) | pad;
  assign fill_data = pad ? 8'h00 : in_byte;
  assign bank_full = fill_we & (fill_ptr == 9'd511);
  assign bank_rel = (state == WAIT_DONE) & wr_done;
`ifdef SECTOR_PACKER_FLUSH_EN
  // padding runs until the fill pointer wraps, which marks the bank full
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) pad <= 1'b0;
    else if (bank_full) pad <= 1'b0;
    else if (flush && fill_ptr != 9'd0) pad <= 1'b1;
`else
  assign pad = 1'b0;
`endif
  always_ff @(posedge clk)
    if (fill_we) mem[{fill_bank, fill_ptr}] <= fill_data;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      fill_bank <= 1'b0;
      drain_bank <= 1'b0;
      fill_ptr <= 9'd0;
      rd_ptr <= 9'd0;
      full_cnt <= 2'd0;
      wr_start <= 1'b0;
      wr_sector <= BASE_SECTOR;
      wr_byte <= 8'h00;
      sectors_done <= 32'd0;
      overflow <= 1'b0;
      halted <= 1'b0;
    end else begin
      if (fill_we) fill_ptr <= fill_ptr + 9'd1;
      if (bank_full) fill_bank <= ~fill_bank;
      full_cnt <= full_cnt + {1'b0, bank_full} - {1'b0, bank_rel};
      if (in_en & ~in_ready) overflow <= 1'b1;
      wr_start <= 1'b0;
      case (state)
        IDLE: if (full_cnt != 2'd0 && !wr_busy && !halted) begin
          state <= START;
          wr_start <= 1'b1;
          wr_byte <= mem[{drain_bank, 9'd0}];
          rd_ptr <= 9'd0;
        end
        START: state <= XFER;
        XFER: if (wr_byte_ack) begin
          rd_ptr <= rd_ptr + 9'd1;
          wr_byte <= mem[{drain_bank, rd_ptr + 9'd1}];
          if (rd_ptr == 9'd511) state <= WAIT_DONE;
        end
        WAIT_DONE: if (wr_done) begin
          drain_bank <= ~drain_bank;
          wr_sector <= wr_sector + 32'd1;
          sectors_done <= sectors_done + 32'd1;
          if (MAX_SECTORS != 32'd0 && sectors_done + 32'd1 == MAX_SECTORS) halted <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_sector_packer.sv
// tb_sd_sector_packer: directed vectors and multi-cycle sequences for sd_sector_packer.
module tb_sd_sector_packer;
  localparam logic [31:0] BASE = 32'h0000_0100;
  logic clk = 1'b0, rstn = 1'b0, in_en = 1'b0, wr_busy = 1'b0, wr_byte_ack = 1'b0, wr_done = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic in_ready, wr_start, overflow, halted;
  logic [31:0] wr_sector, sectors_done;
  logic [7:0] wr_byte;
`ifdef SECTOR_PACKER_FLUSH_EN
  logic flush = 1'b0;
`endif
  int total = 0, passed = 0, starts;

  always #5 clk = ~clk;

  sd_sector_packer #(.BASE_SECTOR(BASE), .MAX_SECTORS(32'd2)) dut (
    .clk(clk), .rstn(rstn), .in_en(in_en), .in_byte(in_byte), .in_ready(in_ready),
    .wr_busy(wr_busy), .wr_start(wr_start), .wr_sector(wr_sector), .wr_byte(wr_byte),
    .wr_byte_ack(wr_byte_ack), .wr_done(wr_done), .sectors_done(sectors_done),
    .overflow(overflow),
`ifdef SECTOR_PACKER_FLUSH_EN
    .flush(flush),
`endif
    .halted(halted)
  );

  always @(posedge clk or negedge rstn)
    if (!rstn) starts <= 0;
    else if (wr_start) starts <= starts + 1;

  typedef struct {
    logic in_en;
    logic [7:0] in_byte;
    logic wr_busy, ack, done;
    logic exp_ready, exp_start;
    logic [31:0] exp_sectors;
    logic exp_ovf;
  } vec_t;
  vec_t vecs[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] pat(input int kind, input int i);
    logic [31:0] v;
    v = (kind == 0) ? i : (kind == 1) ? i * 7 + 3 :
        (i == 0) ? 32'hAA : (i == 1) ? 32'hBB : (i == 2) ? 32'hCC : 32'h00;
    return v[7:0];
  endfunction

  task automatic do_reset();
    rstn = 1'b0; in_en = 1'b0; wr_busy = 1'b0; wr_byte_ack = 1'b0; wr_done = 1'b0;
`ifdef SECTOR_PACKER_FLUSH_EN
    flush = 1'b0;
`endif
    tick(); tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic push(input int kind, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      in_en = 1'b1;
      in_byte = pat(kind, base + i);
      tick();
    end
    in_en = 1'b0;
  endtask

  task automatic wait_start(input logic [31:0] exp_sector);
    int n = 0;
    while (!wr_start && n < 2000) begin tick(); n++; end
    chk("wr_start seen", {31'd0, wr_start}, 32'd1);
    chk("wr_sector at start", wr_sector, exp_sector);
    tick();
    chk("wr_start one cycle", {31'd0, wr_start}, 32'd0);
  endtask

  task automatic xfer(input int kind, input int base, input string name);
    int errs = 0;
    for (int i = 0; i < 512; i++) begin
      if (wr_byte !== pat(kind, base + i)) errs++;
      wr_byte_ack = 1'b1;
      tick();
    end
    wr_byte_ack = 1'b0;
    chk(name, errs, 32'd0);
  endtask

  task automatic finish_sector(input logic [31:0] exp_done, input logic [31:0] exp_next);
    wr_done = 1'b1;
    tick();
    wr_done = 1'b0;
    chk("sectors_done after done", sectors_done, exp_done);
    chk("wr_sector after done", wr_sector, exp_next);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[3] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0, 1'b0};
    vecs[5] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0};

    do_reset();
    chk("reset in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset wr_start", {31'd0, wr_start}, 32'd0);
    chk("reset wr_sector", wr_sector, BASE);
    chk("reset wr_byte", {24'd0, wr_byte}, 32'd0);
    chk("reset sectors_done", sectors_done, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset halted", {31'd0, halted}, 32'd0);

    for (int v = 0; v < 6; v++) begin
      in_en = vecs[v].in_en; in_byte = vecs[v].in_byte; wr_busy = vecs[v].wr_busy;
      wr_byte_ack = vecs[v].ack; wr_done = vecs[v].done;
      tick();
      chk($sformatf("vec%0d in_ready", v), {31'd0, in_ready}, {31'd0, vecs[v].exp_ready});
      chk($sformatf("vec%0d wr_start", v), {31'd0, wr_start}, {31'd0, vecs[v].exp_start});
      chk($sformatf("vec%0d sectors_done", v), sectors_done, vecs[v].exp_sectors);
      chk($sformatf("vec%0d overflow", v), {31'd0, overflow}, {31'd0, vecs[v].exp_ovf});
    end
    in_en = 1'b0; wr_busy = 1'b0; wr_byte_ack = 1'b0; wr_done = 1'b0;

    // single sector with start latency
    do_reset();
    push(0, 0, 512);
    chk("latency no early start", {31'd0, wr_start}, 32'd0);
    tick();
    chk("latency wr_start", {31'd0, wr_start}, 32'd1);
    wait_start(BASE);
    xfer(0, 0, "sector1 data");
    wr_byte_ack = 1'b1;
    tick(); tick(); tick();
    wr_byte_ack = 1'b0;
    chk("extra acks no effect", sectors_done, 32'd0);
    finish_sector(32'd1, BASE + 32'd1);
    chk("sector1 overflow", {31'd0, overflow}, 32'd0);
    chk("sector1 start count", starts, 32'd1);

    // stalled writer, overflow, then halt after two sectors
    do_reset();
    wr_busy = 1'b1;
    push(1, 0, 1024);
    chk("stall in_ready low", {31'd0, in_ready}, 32'd0);
    chk("stall overflow clear", {31'd0, overflow}, 32'd0);
    push(1, 1024, 512);
    chk("stall overflow set", {31'd0, overflow}, 32'd1);
    chk("busy blocks start", starts, 32'd0);
    wr_busy = 1'b0;
    wait_start(BASE);
    xfer(1, 0, "stall bank0 data");
    finish_sector(32'd1, BASE + 32'd1);
    wait_start(BASE + 32'd1);
    xfer(1, 512, "stall bank1 data");
    finish_sector(32'd2, BASE + 32'd2);
    chk("halted set", {31'd0, halted}, 32'd1);
    chk("halted in_ready", {31'd0, in_ready}, 32'd0);
    repeat (5) tick();
    chk("halt start count", starts, 32'd2);

    // last fill byte coincides with wr_done of the other bank
    do_reset();
    push(0, 0, 512);
    wait_start(BASE);
    push(1, 0, 511);
    xfer(0, 0, "simul bank0 data");
    in_en = 1'b1; in_byte = pat(1, 511); wr_done = 1'b1;
    tick();
    in_en = 1'b0; wr_done = 1'b0;
    chk("simul sectors_done", sectors_done, 32'd1);
    chk("simul in_ready", {31'd0, in_ready}, 32'd1);
    wait_start(BASE + 32'd1);
    xfer(1, 0, "simul bank1 data");
    finish_sector(32'd2, BASE + 32'd2);

    // reset mid-transfer
    do_reset();
    push(0, 0, 512);
    wait_start(BASE);
    wr_byte_ack = 1'b1;
    repeat (100) tick();
    wr_byte_ack = 1'b0;
    rstn = 1'b0;
    #2;
    chk("midreset in_ready", {31'd0, in_ready}, 32'd1);
    chk("midreset wr_start", {31'd0, wr_start}, 32'd0);
    chk("midreset wr_sector", wr_sector, BASE);
    chk("midreset wr_byte", {24'd0, wr_byte}, 32'd0);
    chk("midreset sectors_done", sectors_done, 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    push(1, 0, 512);
    wait_start(BASE);
    xfer(1, 0, "post-reset data");
    finish_sector(32'd1, BASE + 32'd1);

`ifdef SECTOR_PACKER_FLUSH_EN
    do_reset();
    push(2, 0, 3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush in_ready low", {31'd0, in_ready}, 32'd0);
    wait_start(BASE);
    xfer(2, 0, "flush data");
    finish_sector(32'd1, BASE + 32'd1);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
